// File: rtl/mem_stage_sram.sv
// Purpose: MEM pipeline stage that maps a 32-bit word access onto a 16-bit external SRAM, plus the MEM/WB register.
// Latency: non-memory ops 1 cycle; memory ops freeze the pipe for 1+2*WAIT_CYCLES cycles and retire in DONE.
// Backpressure: ready is combinational; while it is 0 upstream holds its inputs and MEM/WB loads bubbles.
//
// Ports:
//   clk, rst                             clock, async active-high reset
//   wb_en_in, mem_r_en_in, mem_w_en_in   EXE/MEM control bits
//   alu_result_in, val_rm_in, dest_in    byte address / ALU result, store data, destination index
//   ready                                0 = freeze upstream stages and the EXE/MEM register
//   wb_en, mem_r_en, alu_result,
//   mem_data, dest                       registered MEM/WB outputs
//   sram_addr, sram_wdata, sram_we_n,
//   sram_rdata                           external 16-bit SRAM port (half-word addressed)
module mem_stage_sram #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        ready,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_result,
  output logic [31:0] mem_data,
  output logic [3:0]  dest,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_we_n,
  input  logic [15:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        is_wr;
  logic        is_rd;
  logic        last_cnt;
  logic [16:0] word_addr;

  // A simultaneous read+write request is treated as a write only.
  assign req       = mem_r_en_in | mem_w_en_in;
  assign is_wr     = mem_w_en_in;
  assign is_rd     = mem_r_en_in & ~mem_w_en_in;
  assign last_cnt  = (cnt_q == LAST_CNT);
  assign word_addr = 17'((alu_result_in - BASE_ADDR) >> 2);

  // Access sequencer. Inputs are frozen by upstream while ready=0, so they
  // are read directly throughout the access rather than captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= LO;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
          end
        end
        LO: begin
          if (last_cnt) begin
            if (is_rd) rdata_q[15:0] <= sram_rdata;
            state_q <= HI;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HI: begin
          if (last_cnt) begin
            if (is_rd) rdata_q[31:16] <= sram_rdata;
            state_q <= DONE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        // Always return to IDLE so a request still held by the freeze is
        // seen as a fresh op only once upstream has advanced.
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // SRAM drive and stall decode. Reset forces IDLE asynchronously, which
  // releases the SRAM bus immediately and kills any in-flight write.
  always_comb begin
    ready      = 1'b0;
    sram_addr  = 18'd0;
    sram_wdata = 16'h0000;
    sram_we_n  = 1'b1;
    case (state_q)
      IDLE: ready = ~req;
      LO: begin
        sram_addr = {word_addr, 1'b0};
        if (is_wr) begin
          sram_we_n  = 1'b0;
          sram_wdata = val_rm_in[15:0];
        end
      end
      HI: begin
        sram_addr = {word_addr, 1'b1};
        if (is_wr) begin
          sram_we_n  = 1'b0;
          sram_wdata = val_rm_in[31:16];
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // MEM/WB register: real op when ready, bubble otherwise.
  logic        wb_en_d, mem_r_en_d;
  logic [31:0] alu_result_d, mem_data_d;
  logic [3:0]  dest_d;

  always_comb begin
    wb_en_d      = 1'b0;
    mem_r_en_d   = 1'b0;
    alu_result_d = 32'd0;
    mem_data_d   = 32'd0;
    dest_d       = 4'd0;
    if (ready) begin
      wb_en_d      = wb_en_in;
      mem_r_en_d   = mem_r_en_in;
      alu_result_d = alu_result_in;
      mem_data_d   = is_rd ? rdata_q : 32'd0;
      dest_d       = dest_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      alu_result <= 32'd0;
      mem_data   <= 32'd0;
      dest       <= 4'd0;
    end else begin
      wb_en      <= wb_en_d;
      mem_r_en   <= mem_r_en_d;
      alu_result <= alu_result_d;
      mem_data   <= mem_data_d;
      dest       <= dest_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  localparam int          WAIT = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_result_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        ready;
  logic        wb_en, mem_r_en;
  logic [31:0] alu_result, mem_data;
  logic [3:0]  dest;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we_n;
  logic [15:0] sram_rdata;

  mem_stage_sram #(.WAIT_CYCLES(WAIT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .ready(ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
    .mem_data(mem_data), .dest(dest),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write on rising edge while we_n is low.
  logic [15:0] smem [0:262143];
  int          wr_cnt = 0;
  assign sram_rdata = smem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) begin
      smem[sram_addr] <= sram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic [31:0] alu;
    logic [31:0] md;
    logic [3:0]  dst;
  } wbx_t;

  wbx_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy0_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one op (entered on a falling edge) and checks every cycle until it retires.
  task automatic run_op(input logic wb, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] val, input logic [3:0] d);
    logic        is_req, is_wr, is_rd, exp_rdy, exp_we;
    logic [16:0] wa;
    logic [17:0] exp_addr;
    logic [15:0] exp_wd;
    logic [31:0] exp_md;
    wbx_t        e, o;
    int          last, ph;
    wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
    alu_result_in = alu; val_rm_in = val; dest_in = d;
    is_req = rd | wr;
    is_wr  = wr;
    is_rd  = rd & !wr;
    last   = is_req ? 2 * WAIT + 1 : 0;
    wa     = 17'((alu - BASE) >> 2);
    exp_md = is_rd ? {smem[{wa, 1'b1}], smem[{wa, 1'b0}]} : 32'h0;
    for (int k = 0; k <= last; k++) begin
      #1;
      exp_rdy  = (k == last);
      ph       = (k >= 1 && k <= WAIT) ? 1 : ((k > WAIT && k <= 2 * WAIT) ? 2 : 0);
      exp_addr = (ph == 1) ? {wa, 1'b0} : ((ph == 2) ? {wa, 1'b1} : 18'h0);
      exp_wd   = (is_wr && ph == 1) ? val[15:0] : ((is_wr && ph == 2) ? val[31:16] : 16'h0);
      exp_we   = !(is_wr && ph != 0);
      if (!ready) rdy0_cnt++;
      check("ready", 64'(ready), 64'(exp_rdy));
      check("sram_addr", 64'(sram_addr), 64'(exp_addr));
      check("sram_wdata", 64'(sram_wdata), 64'(exp_wd));
      check("sram_we_n", 64'(sram_we_n), 64'(exp_we));
      if (exp_rdy) e = '{wb, rd, alu, exp_md, d};
      else         e = '0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("sb_empty", 64'(1), 64'(0));
      end else begin
        o = sb.pop_front();
        check("wb_en", 64'(wb_en), 64'(o.wb));
        check("mem_r_en", 64'(mem_r_en), 64'(o.rd));
        check("alu_result", 64'(alu_result), 64'(o.alu));
        check("mem_data", 64'(mem_data), 64'(o.md));
        check("dest", 64'(dest), 64'(o.dst));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, w0;
    for (int i = 0; i < 262144; i++) smem[i] = 16'h0000;
    smem[4] = 16'h1234;
    smem[5] = 16'h5678;
    rst = 1'b1;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    alu_result_in = 32'd0; val_rm_in = 32'd0; dest_in = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_wb_en", 64'(wb_en), 64'(0));
    check("rst_mem_data", 64'(mem_data), 64'(0));
    check("rst_we_n", 64'(sram_we_n), 64'(1));
    check("rst_addr", 64'(sram_addr), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Non-memory op and an idle cycle
    run_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
    run_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);

    // Single write, then read it back
    w0 = wr_cnt; r0 = rdy0_cnt;
    run_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0);
    check("wr_cycles", 64'(wr_cnt - w0), 64'(2 * WAIT));
    check("wr_ready0", 64'(rdy0_cnt - r0), 64'(1 + 2 * WAIT));
    check("wr_lo_word", 64'(smem[2]), 64'(16'hBEEF));
    check("wr_hi_word", 64'(smem[3]), 64'(16'hDEAD));
    run_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd7);

    // Back-to-back read then write
    w0 = wr_cnt; r0 = rdy0_cnt;
    run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5);
    run_op(1'b0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 4'd0);
    check("b2b_ready0", 64'(rdy0_cnt - r0), 64'(10));
    check("b2b_writes", 64'(wr_cnt - w0), 64'(2 * WAIT));
    check("b2b_word", 64'({smem[7], smem[6]}), 64'(32'hCAFEF00D));

    // Read and write together: performed as a write, mem_data 0
    w0 = wr_cnt;
    run_op(1'b1, 1'b1, 1'b1, 32'd1040, 32'h11112222, 4'd2);
    check("rw_writes", 64'(wr_cnt - w0), 64'(2 * WAIT));
    run_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd9);

    // Reset in the first HI cycle of a write
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
    alu_result_in = 32'd1044; val_rm_in = 32'hAAAA5555; dest_in = 4'd0;
    w0 = wr_cnt;
    repeat (WAIT + 1) @(posedge clk);
    @(negedge clk);
    #1;
    check("hi_we_n", 64'(sram_we_n), 64'(0));
    check("hi_addr", 64'(sram_addr), 64'(11));
    rst = 1'b1;
    #1;
    check("abort_we_n", 64'(sram_we_n), 64'(1));
    check("abort_addr", 64'(sram_addr), 64'(0));
    check("abort_wdata", 64'(sram_wdata), 64'(0));
    check("abort_outs", 64'({wb_en, mem_r_en, alu_result, mem_data, dest}), 64'(0));
    mem_w_en_in = 1'b0;
    alu_result_in = 32'd0;
    val_rm_in = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_writes", 64'(wr_cnt - w0), 64'(WAIT));
    check("abort_lo_word", 64'(smem[10]), 64'(16'h5555));
    check("abort_hi_word", 64'(smem[11]), 64'(16'h0000));
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(ready), 64'(1));
    @(negedge clk);
    run_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
